uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-data FIFO for the APB UART. Sits directly downstream of the UART receiver.
//   Captures each completed RX character on a one-cycle write pulse and back-pressures via full.
//   Presents the oldest character show-ahead to the APB register block, which pops it on read.
//   Provides level, programmable-threshold and sticky overflow status for interrupt generation.
// PARAMETERS
//   DATA_WIDTH   `CFG_DATA_WIDTH  width of one stored character (low bits of the APB data bus)
//   DEPTH        16               number of entries; must be a power of 2, >= 2
//   ADDR_WIDTH   $clog2(DEPTH)    pointer width (derived, not overridden)
// PORTS
//   clk            in   1              system clock
//   reset          in   1              asynchronous, active-high reset
//   wr_req         in   1              push request (receiver rx-done pulse)
//   data_in        in   DATA_WIDTH     character to push
//   full           out  1              level == DEPTH (drives receiver fifo-full / RTS logic)
//   rd_req         in   1              pop request (APB read of RX data register)
//   data_out       out  DATA_WIDTH     head entry, show-ahead; 0 when empty
//   empty          out  1              level == 0
//   level          out  ADDR_WIDTH+1   current number of stored entries, 0..DEPTH
//   flush          in   1              synchronous clear of contents (FCR RX-reset bit)
//   threshold      in   ADDR_WIDTH+1   interrupt trigger level; 0 disables
//   threshold_hit  out  1              registered: level >= threshold && threshold != 0
//   overflow       out  1              sticky: a push was dropped
//   overflow_clr   in   1              clears overflow (LSR read side effect)
// BEHAVIOUR
//   - Reset (async, reset=1): wr_ptr=rd_ptr=0, level=0, empty=1, full=0, overflow=0,
//     threshold_hit=0, data_out=0. Memory contents are not reset. Reset mid-operation discards all data.
//   - Storage: DEPTH x DATA_WIDTH register array. wr_ptr/rd_ptr ADDR_WIDTH bits wide; they wrap
//     DEPTH-1 -> 0 naturally. level is a separate ADDR_WIDTH+1 counter.
//   - push_ok = wr_req && (!full || rd_req). pop_ok = rd_req && !empty. Both are evaluated on
//     registered state at the start of the cycle.
//   - Push: mem[wr_ptr] <= data_in, wr_ptr++. Pop: rd_ptr++. level += push_ok - pop_ok.
//   - Simultaneous push+pop while full: both accepted, level stays DEPTH, no overflow.
//   - Simultaneous push+pop while empty: push accepted, pop ignored (no bypass), level becomes 1.
//   - Pop while empty: ignored; pointers, level and flags unchanged.
//   - data_out = mem[rd_ptr] when !empty, else 0. A pushed word is visible on data_out the cycle
//     after the push (1-cycle write-to-read latency). After a pop, the next entry shows on the following cycle.
//   - full/empty are decoded from the registered level; they update the cycle after the push/pop.
//   - overflow: set when wr_req && full && !rd_req. overflow_clr clears it. If set and clear
//     occur in the same cycle, set wins. Dropped data never modifies memory.
//   - flush: has priority over push and pop in the same cycle. Pointers and level go to 0 and
//     empty=1 next cycle. overflow is unaffected. threshold_hit recomputes from the new level.
//   - threshold_hit: registered compare of next-state level against threshold, so it is aligned
//     with level. Changing threshold takes effect on the next clock.
//   - wr_req is treated as a single-cycle pulse but must work when held high (one push per cycle).
// TESTING
//   1 Fill: 16 pushes 0x00..0x0F, no reads -> level=16, full=1, empty=0, overflow=0, data_out=0x00.
//   2 Overflow: when full, push 0xAA -> overflow=1, level=16. 16 pops return 0x00..0x0F, then empty=1
//     and data_out=0. overflow_clr -> overflow=0.
//   3 Wrap: push/pop 10, then push 0x30..0x39 -> pops return 0x30..0x39 in order (ptrs wrapped past 15).
//   4 Simultaneous: when full, push 0x55 + pop -> pop gets head, level=16, overflow=0, 0x55 is last out.
//     When empty, push+pop -> level=1, data_out=pushed value.
//   5 Threshold: threshold=4. 3 pushes -> hit=0. 4th push -> hit=1 next cycle. 1 pop -> hit=0.
//     With threshold=0, hit stays 0 at any level.
//   6 Flush/reset: 5 entries with flush+push same cycle -> level=0, empty=1, overflow preserved.
//     Async reset mid-push -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-data FIFO between the UART receiver and the APB register block.
// Show-ahead head output, level/threshold status and sticky overflow.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   threshold,
    output logic                  threshold_hit,
    output logic                  overflow,
    input  logic                  overflow_clr
);
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   level_nxt;
    logic                  push_ok, pop_ok, ovf_set;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    // A pop frees the slot in the same cycle, so a push is accepted even when full.
    assign push_ok = wr_req && (!full || rd_req);
    assign pop_ok  = rd_req && !empty;
    assign ovf_set = wr_req && full && !rd_req;

    always_comb begin
        level_nxt = level;
        if (flush)
            level_nxt = '0;
        else
            level_nxt = level + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            overflow      <= 1'b0;
            threshold_hit <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            level         <= level_nxt;
            threshold_hit <= (threshold != '0) && (level_nxt >= threshold);
            // Set wins over a coincident clear.
            if (ovf_set)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= data_in;
    end

    assign data_out = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected characters queued on push,
// compared against the show-ahead output on pop.
module tb_uart_rx_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_req = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          full;
    logic          rd_req = 1'b0;
    logic [DW-1:0] data_out;
    logic          empty;
    logic [AW:0]   level;
    logic          flush = 1'b0;
    logic [AW:0]   threshold = '0;
    logic          threshold_hit;
    logic          overflow;
    logic          overflow_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb[$];

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .data_in(data_in), .full(full),
        .rd_req(rd_req), .data_out(data_out), .empty(empty), .level(level),
        .flush(flush), .threshold(threshold), .threshold_hit(threshold_hit),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_req = 1'b1; data_in = d;
        tick();
        wr_req = 1'b0;
        sb.push_back(d);
    endtask

    task automatic pop_cmp(input string name);
        logic [DW-1:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, data_out=%0h", name, data_out);
        end else begin
            exp = sb.pop_front();
            if (data_out !== exp) begin
                errors++;
                $display("FAIL %s: data_out=%0h expected %0h", name, data_out, exp);
            end
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({level, empty, full, overflow, threshold_hit, data_out} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset: level=%0d empty=%b full=%b ovf=%b hit=%b dout=%0h expected 0 1 0 0 0 0",
                     level, empty, full, overflow, threshold_hit, data_out);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) push(DW'(i));
        checks++;
        if ({level, full, empty, overflow, data_out} !== {5'd16, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL fill: level=%0d full=%b empty=%b ovf=%b dout=%0h expected 16 1 0 0 0",
                     level, full, empty, overflow, data_out);
        end
        wr_req = 1'b1; data_in = 8'hAA;
        tick();
        wr_req = 1'b0;
        checks++;
        if ({overflow, level} !== {1'b1, 5'd16}) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b level=%0d expected 1 16", overflow, level);
        end
        for (int i = 0; i < DEPTH; i++) pop_cmp("drain");
        checks++;
        if ({empty, data_out, level} !== {1'b1, 8'h00, 5'd0}) begin
            errors++;
            $display("FAIL drained: empty=%b dout=%0h level=%0d expected 1 0 0", empty, data_out, level);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        checks++;
        if ({empty, level} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL pop_empty: empty=%b level=%0d expected 1 0", empty, level);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clr: ovf=%b expected 0", overflow);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            push(8'h20 + DW'(i));
            pop_cmp("wrap_pre");
        end
        for (int i = 0; i < 10; i++) push(8'h30 + DW'(i));
        checks++;
        if (level !== 5'd10) begin
            errors++;
            $display("FAIL wrap_level: level=%0d expected 10", level);
        end
        for (int i = 0; i < 10; i++) pop_cmp("wrap");
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] exp;
        for (int i = 0; i < DEPTH; i++) push(8'h40 + DW'(i));
        exp = sb.pop_front();
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL simul_full_head: dout=%0h expected %0h", data_out, exp);
        end
        wr_req = 1'b1; rd_req = 1'b1; data_in = 8'h55;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        sb.push_back(8'h55);
        checks++;
        if ({level, overflow} !== {5'd16, 1'b0}) begin
            errors++;
            $display("FAIL simul_full: level=%0d ovf=%b expected 16 0", level, overflow);
        end
        wr_req = 1'b1; overflow_clr = 1'b1; data_in = 8'hEE;
        tick();
        wr_req = 1'b0; overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: ovf=%b expected 1", overflow);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) pop_cmp("simul_drain");
        wr_req = 1'b1; rd_req = 1'b1; data_in = 8'h77;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        sb.push_back(8'h77);
        checks++;
        if ({level, data_out} !== {5'd1, 8'h77}) begin
            errors++;
            $display("FAIL simul_empty: level=%0d dout=%0h expected 1 77", level, data_out);
        end
        pop_cmp("simul_empty_pop");
    endtask

    task automatic test_threshold();
        threshold = 5'd4;
        tick();
        for (int i = 0; i < 3; i++) push(8'h60 + DW'(i));
        checks++;
        if (threshold_hit !== 1'b0) begin
            errors++;
            $display("FAIL thr_below: hit=%b expected 0", threshold_hit);
        end
        push(8'h63);
        checks++;
        if ({threshold_hit, level} !== {1'b1, 5'd4}) begin
            errors++;
            $display("FAIL thr_reach: hit=%b level=%0d expected 1 4", threshold_hit, level);
        end
        pop_cmp("thr_pop");
        checks++;
        if (threshold_hit !== 1'b0) begin
            errors++;
            $display("FAIL thr_drop: hit=%b expected 0", threshold_hit);
        end
        threshold = 5'd0;
        for (int i = 0; i < 13; i++) begin
            push(8'h70 + DW'(i));
            checks++;
            if (threshold_hit !== 1'b0) begin
                errors++;
                $display("FAIL thr_disabled: hit=%b level=%0d expected 0", threshold_hit, level);
            end
        end
        for (int i = 0; i < 16; i++) pop_cmp("thr_drain");
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < DEPTH; i++) push(DW'(i));
        wr_req = 1'b1; data_in = 8'hBB;
        tick();
        wr_req = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        for (int i = 0; i < 5; i++) push(8'h80 + DW'(i));
        flush = 1'b1; wr_req = 1'b1; data_in = 8'hCC;
        tick();
        flush = 1'b0; wr_req = 1'b0;
        sb.delete();
        checks++;
        if ({level, empty, overflow, data_out} !== {5'd0, 1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL flush: level=%0d empty=%b ovf=%b dout=%0h expected 0 1 1 0",
                     level, empty, overflow, data_out);
        end
        push(8'h91);
        push(8'h92);
        pop_cmp("post_flush");
        threshold = 5'd1;
        wr_req = 1'b1; data_in = 8'h93;
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({level, empty, full, overflow, threshold_hit, data_out} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset: level=%0d empty=%b full=%b ovf=%b hit=%b dout=%0h expected 0 1 0 0 0 0",
                     level, empty, full, overflow, threshold_hit, data_out);
        end
        wr_req = 1'b0; threshold = 5'd0;
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
        push(8'hA5);
        pop_cmp("after_reset");
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_simultaneous();
        test_threshold();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
